// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
package dcache_pkg;
  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 32;
  localparam int MADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  // Pick byte 'off' out of a block; byte0 lives in [7:0].
  function automatic logic [7:0] byte_sel(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFF_W-1:0]   off);
    return blk[{off, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/dcache_if.sv
// CPU-side and block-memory-side buses of the data cache.
interface dcache_if;
  import dcache_pkg::*;

  logic                 read;
  logic                 write;
  logic [7:0]           address;
  logic [7:0]           writedata;
  logic [7:0]           readdata;
  logic                 busywait;

  logic                 mem_read;
  logic                 mem_write;
  logic [MADDR_W-1:0]   mem_address;
  logic [BLOCK_W-1:0]   mem_writedata;
  logic [BLOCK_W-1:0]   mem_readdata;
  logic                 mem_busywait;

  // CPU issuing requests / cache answering them
  modport master (output read, write, address, writedata,
                  input  readdata, busywait);
  modport slave  (input  read, write, address, writedata,
                  output readdata, busywait);
  // cache issuing block transfers / memory answering them
  modport mem_master (output mem_read, mem_write, mem_address, mem_writedata,
                      input  mem_readdata, mem_busywait);
  modport mem_slave  (input  mem_read, mem_write, mem_address, mem_writedata,
                      output mem_readdata, mem_busywait);
endinterface

// File: rtl/dcache_array.sv
// Block storage: valid/dirty flags (async clear) plus tag/data (no reset).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NBLOCKS = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IDX_W-1:0]   idx,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag,
  output logic [BLOCK_W-1:0] data,
  input  logic               wr_en,
  input  logic [OFF_W-1:0]   wr_off,
  input  logic [7:0]         wr_byte,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data
);
  logic [NBLOCKS-1:0]              valid_q;
  logic [NBLOCKS-1:0]              dirty_q;
  logic [NBLOCKS-1:0][TAG_W-1:0]   tag_q;
  logic [NBLOCKS-1:0][BLOCK_W-1:0] data_q;

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];

  // Flags: a fill makes the block valid and clean, a byte write dirties it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag/data payload; contents are meaningless until valid is set.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (wr_en) begin
      data_q[idx][{wr_off, 3'b000} +: 8] <= wr_byte;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: zero-stall hits, writeback+fetch on miss.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NBLOCKS = 8
) (
  input  logic clock,
  input  logic reset,
  dcache_if.slave      cpu,
  dcache_if.mem_master mem
);
  state_t               state;
  logic                 v_rd, d_rd;
  logic [TAG_W-1:0]     tag_rd;
  logic [BLOCK_W-1:0]   data_rd;
  logic                 mrd_q, mwr_q;
  logic [MADDR_W-1:0]   maddr_q;
  logic [BLOCK_W-1:0]   mwdata_q;

  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  assign a_tag = cpu.address[7:5];
  assign a_idx = cpu.address[4:2];
  assign a_off = cpu.address[1:0];

  // read and write together is treated as no request at all
  logic rd_req, wr_req, req, hit, idle, wr_hit_en, fill_en;
  assign rd_req    = cpu.read & ~cpu.write;
  assign wr_req    = cpu.write & ~cpu.read;
  assign req       = rd_req | wr_req;
  assign hit       = v_rd && (tag_rd == a_tag);
  assign idle      = (state == IDLE);
  assign wr_hit_en = reset & idle & wr_req & hit;
  assign fill_en   = (state == FETCH) & ~mem.mem_busywait;

  assign cpu.busywait = reset & (~idle | (req & ~hit));
  assign cpu.readdata = (reset & idle & rd_req & hit) ? byte_sel(data_rd, a_off) : 8'h00;

  assign mem.mem_read      = mrd_q;
  assign mem.mem_write     = mwr_q;
  assign mem.mem_address   = maddr_q;
  assign mem.mem_writedata = mwdata_q;

  dcache_array #(.NBLOCKS(NBLOCKS)) u_array (
    .clock     (clock),
    .reset     (reset),
    .idx       (a_idx),
    .valid     (v_rd),
    .dirty     (d_rd),
    .tag       (tag_rd),
    .data      (data_rd),
    .wr_en     (wr_hit_en),
    .wr_off    (a_off),
    .wr_byte   (cpu.writedata),
    .fill_en   (fill_en),
    .fill_tag  (a_tag),
    .fill_data (mem.mem_readdata)
  );

  // Miss FSM; strobe, address and writeback data are latched on entry to a
  // state so they cannot move while the memory is still busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          if (v_rd && d_rd) begin
            state    <= WRITEBACK;
            mwr_q    <= 1'b1;
            maddr_q  <= {tag_rd, a_idx};
            mwdata_q <= data_rd;
          end else begin
            state   <= FETCH;
            mrd_q   <= 1'b1;
            maddr_q <= {a_tag, a_idx};
          end
        end
        WRITEBACK: if (!mem.mem_busywait) begin
          state   <= FETCH;
          mwr_q   <= 1'b0;
          mrd_q   <= 1'b1;
          maddr_q <= {a_tag, a_idx};
        end
        FETCH: if (!mem.mem_busywait) begin
          state <= IDLE;
          mrd_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          mrd_q <= 1'b0;
          mwr_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench: cold miss, write hit, dirty eviction, stalled memory,
// read+write conflict, reset mid-fetch, write miss.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk, rst_n, mbusy;
  int   total, bad;
  int   rd_cnt, wb_cnt, ovl_cnt;
  logic [31:0] mem_blk [64];

  dcache_if bus ();

  dcache_controller #(.NBLOCKS(8)) dut (
    .clock (clk),
    .reset (rst_n),
    .cpu   (bus),
    .mem   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // block memory model: byte k of block b is {k[1:0], b[5:0]}
  assign bus.mem_readdata = mem_blk[bus.mem_address];
  assign bus.mem_busywait = mbusy;

  always @(posedge clk) begin
    if (bus.mem_write && !mbusy) mem_blk[bus.mem_address] <= bus.mem_writedata;
    if (bus.mem_read)  rd_cnt  <= rd_cnt + 1;
    if (bus.mem_write) wb_cnt  <= wb_cnt + 1;
    if (bus.mem_read && bus.mem_write) ovl_cnt <= ovl_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0; rd_cnt = 0; wb_cnt = 0; ovl_cnt = 0;
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) mem_blk[b][k*8 +: 8] = {k[1:0], b[5:0]};
    rst_n = 1'b0; mbusy = 1'b0;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 8'h00; bus.writedata = 8'h00;
    repeat (2) tick();

    // reset: request pending but outputs held quiet
    bus.read = 1'b1; bus.address = 8'h25; #1;
    check("rst_busy",  bus.busywait,  0);
    check("rst_rdata", bus.readdata,  0);
    check("rst_mrd",   bus.mem_read,  0);
    check("rst_mwr",   bus.mem_write, 0);
    #2 rst_n = 1'b1; #1;

    // cold read 0x25 -> fetch block 0x09, byte1 = 0x49
    check("cold_busy", bus.busywait, 1);
    tick();
    check("cold_mrd",   bus.mem_read,    1);
    check("cold_maddr", bus.mem_address, 6'h09);
    check("cold_nowb",  bus.mem_write,   0);
    tick();
    check("cold_done",  bus.busywait, 0);
    check("cold_rdata", bus.readdata, 8'h49);
    check("cold_mrd0",  bus.mem_read, 0);
    check("cold_wbcnt", wb_cnt, 0);

    // write hit 0xAB -> 0x26
    bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h26; bus.writedata = 8'hAB; #1;
    check("wh_busy", bus.busywait, 0);
    tick();
    check("wh_busy2", bus.busywait, 0);
    bus.write = 1'b0; #1;
    check("wh_dirty", dut.u_array.dirty_q[1], 1);
    bus.read = 1'b1; #1;
    check("wh_rback", bus.readdata, 8'hAB);
    bus.address = 8'h25; #1;
    check("wh_byte1", bus.readdata, 8'h49);
    check("wh_nomrd", bus.mem_read, 0);

    // dirty eviction: read 0x45 (index 1, tag 2)
    bus.address = 8'h45; #1;
    check("ev_busy", bus.busywait, 1);
    tick();
    check("ev_mwr",    bus.mem_write,     1);
    check("ev_mrd0",   bus.mem_read,      0);
    check("ev_waddr",  bus.mem_address,   6'h09);
    check("ev_wdata",  bus.mem_writedata, 32'hC9AB4909);
    tick();
    check("ev_fetch",  bus.mem_read,  1);
    check("ev_mwr0",   bus.mem_write, 0);
    check("ev_faddr",  bus.mem_address, 6'h11);
    check("ev_memwb",  mem_blk[9], 32'hC9AB4909);
    mbusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_mrd%0d", i),   bus.mem_read, 1);
      check($sformatf("stall_maddr%0d", i), bus.mem_address, 6'h11);
    end
    mbusy = 1'b0;
    tick();
    check("ev_mrd_end", bus.mem_read, 0);
    check("ev_busy0",   bus.busywait, 0);
    check("ev_rdata",   bus.readdata, 8'h51);
    check("ev_rdcnt",   rd_cnt, 7);
    check("ev_wbcnt",   wb_cnt, 1);

    // read and write both high on a missing address: nothing happens
    bus.read = 1'b1; bus.write = 1'b1; bus.address = 8'h85; bus.writedata = 8'hEE; #1;
    check("rw_busy",  bus.busywait, 0);
    check("rw_rdata", bus.readdata, 0);
    tick(); tick();
    check("rw_mrd", bus.mem_read,  0);
    check("rw_mwr", bus.mem_write, 0);
    bus.write = 1'b0; bus.address = 8'h45; #1;
    check("rw_keep",  bus.readdata, 8'h51);
    check("rw_clean", dut.u_array.dirty_q[1], 0);

    // reset mid-fetch of 0x05
    bus.address = 8'h05; #1;
    check("rf_busy", bus.busywait, 1);
    mbusy = 1'b1;
    tick();
    check("rf_mrd",   bus.mem_read,    1);
    check("rf_maddr", bus.mem_address, 6'h01);
    #2 rst_n = 1'b0; #1;
    check("rf_mrd0",  bus.mem_read, 0);
    check("rf_busy0", bus.busywait, 0);
    check("rf_state", 32'(dut.state), 32'(IDLE));
    check("rf_valid", 32'(dut.u_array.valid_q), 0);
    #2 rst_n = 1'b1; #1;
    check("rf_remiss", bus.busywait, 1);
    mbusy = 1'b0;
    tick();
    check("rf_refetch", bus.mem_read, 1);
    tick();
    check("rf_rdata", bus.readdata, 8'h41);

    // write miss 0x3B: fetch block 0x0E, then write applied as a hit
    bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h3B; bus.writedata = 8'h5C; #1;
    check("wm_busy", bus.busywait, 1);
    tick();
    check("wm_maddr", bus.mem_address, 6'h0E);
    tick();
    check("wm_busy0",   bus.busywait, 0);
    check("wm_dirty_b", dut.u_array.dirty_q[6], 0);
    tick();
    check("wm_dirty_a", dut.u_array.dirty_q[6], 1);
    bus.write = 1'b0; bus.read = 1'b1; #1;
    check("wm_rback", bus.readdata, 8'h5C);
    bus.address = 8'h38; #1;
    check("wm_byte0", bus.readdata, 8'h0E);
    bus.read = 1'b0;

    check("no_overlap", ovl_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
